// File: rtl/feature_sum_accum.sv
// Turns four corner beats of three integral-image lanes into a weighted Haar feature sum.
// Three cycles from last corner to result if weights are ready. Upstream stalls outside ACC/WAIT_W and the result is held until feat_ready.
module feature_sum_accum #(
  parameter int W_DATA   = 18,
  parameter int W_WEIGHT = 3,
  parameter int W_CNT    = 12,
  localparam int W_FEAT  = W_DATA + W_WEIGHT + 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       data_valid,
  output logic                       data_ready,
  input  logic [W_DATA-1:0]          data0,
  input  logic [W_DATA-1:0]          data1,
  input  logic [W_DATA-1:0]          data2,
  input  logic [1:0]                 data_eot,
  input  logic                       weight_valid,
  output logic                       weight_ready,
  input  logic signed [W_WEIGHT-1:0] weight0,
  input  logic signed [W_WEIGHT-1:0] weight1,
  input  logic signed [W_WEIGHT-1:0] weight2,
  output logic                       feat_valid,
  input  logic                       feat_ready,
  output logic signed [W_FEAT-1:0]   feat_data,
  output logic                       feat_stage_eot,
  output logic [W_CNT-1:0]           feat_idx,
  output logic                       err
);

  localparam int W_ACC = W_DATA + 2;

  typedef enum logic [1:0] {ACC, WAIT_W, MUL, OUT} state_t;

  state_t                     state;
  logic [1:0]                 corner;
  logic signed [W_ACC-1:0]    acc0, acc1, acc2;
  logic signed [W_WEIGHT-1:0] w0, w1, w2;
  logic                       stage_eot_r;
  logic                       beat_fire;
  logic                       last_beat;
  logic                       neg_corner;
  logic signed [W_ACC-1:0]    ext0, ext1, ext2;
  logic signed [W_FEAT-1:0]   feat_sum;

  assign data_ready   = (state == ACC);
  assign weight_ready = (state == WAIT_W);
  assign beat_fire    = data_valid && data_ready;
  assign last_beat    = data_eot[0] || (corner == 2'd3);
  // Corners 1 and 2 are the off-diagonal corners of the rectangle.
  assign neg_corner   = (corner == 2'd1) || (corner == 2'd2);
  assign ext0         = $signed({2'b00, data0});
  assign ext1         = $signed({2'b00, data1});
  assign ext2         = $signed({2'b00, data2});

  always_comb begin
    feat_sum = W_FEAT'(acc0) * W_FEAT'(w0)
             + W_FEAT'(acc1) * W_FEAT'(w1)
             + W_FEAT'(acc2) * W_FEAT'(w2);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= ACC;
      corner         <= 2'd0;
      acc0           <= '0;
      acc1           <= '0;
      acc2           <= '0;
      w0             <= '0;
      w1             <= '0;
      w2             <= '0;
      stage_eot_r    <= 1'b0;
      feat_data      <= '0;
      feat_valid     <= 1'b0;
      feat_stage_eot <= 1'b0;
      feat_idx       <= '0;
      err            <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (beat_fire) begin
            acc0 <= neg_corner ? acc0 - ext0 : acc0 + ext0;
            acc1 <= neg_corner ? acc1 - ext1 : acc1 + ext1;
            acc2 <= neg_corner ? acc2 - ext2 : acc2 + ext2;
            if (last_beat) begin
              state       <= WAIT_W;
              corner      <= 2'd0;
              stage_eot_r <= data_eot[1];
              // Early eot or a missing eot on the fourth corner are both framing faults.
              if (data_eot[0] != (corner == 2'd3)) err <= 1'b1;
            end else begin
              corner <= corner + 2'd1;
            end
          end
        end
        WAIT_W: begin
          if (weight_valid) begin
            w0    <= weight0;
            w1    <= weight1;
            w2    <= weight2;
            state <= MUL;
          end
        end
        MUL: begin
          feat_data      <= feat_sum;
          feat_stage_eot <= stage_eot_r;
          feat_valid     <= 1'b1;
          state          <= OUT;
        end
        OUT: begin
          if (feat_ready) begin
            feat_valid <= 1'b0;
            acc0       <= '0;
            acc1       <= '0;
            acc2       <= '0;
            feat_idx   <= feat_stage_eot ? '0 : feat_idx + 1'b1;
            state      <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_feature_sum_accum.sv
// Directed bench for feature_sum_accum: latency, stage indexing, backpressure, weight stall, framing, reset.
module tb_feature_sum_accum;

  logic               clk = 1'b0;
  logic               rst;
  logic               data_valid;
  logic               data_ready;
  logic [17:0]        data0, data1, data2;
  logic [1:0]         data_eot;
  logic               weight_valid;
  logic               weight_ready;
  logic signed [2:0]  weight0, weight1, weight2;
  logic               feat_valid;
  logic               feat_ready;
  logic signed [24:0] feat_data;
  logic               feat_stage_eot;
  logic [11:0]        feat_idx;
  logic               err;

  int checks = 0;
  int errors = 0;
  int exp_idx = 0;

  feature_sum_accum dut (
    .clk(clk), .rst(rst),
    .data_valid(data_valid), .data_ready(data_ready),
    .data0(data0), .data1(data1), .data2(data2), .data_eot(data_eot),
    .weight_valid(weight_valid), .weight_ready(weight_ready),
    .weight0(weight0), .weight1(weight1), .weight2(weight2),
    .feat_valid(feat_valid), .feat_ready(feat_ready), .feat_data(feat_data),
    .feat_stage_eot(feat_stage_eot), .feat_idx(feat_idx), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic beat(input logic [17:0] a, input logic [17:0] b, input logic [17:0] c,
                      input logic [1:0] e);
    int n = 0;
    data_valid = 1'b1;
    data0 = a; data1 = b; data2 = c; data_eot = e;
    while (!data_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("beat_timeout", 0, 1);
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  // Reference feature: lane accs 4, 12, 0.
  task automatic run_std(input logic stage_end);
    beat(18'd10, 18'd20, 18'd7, 2'b00);
    beat(18'd4,  18'd5,  18'd7, 2'b00);
    beat(18'd3,  18'd5,  18'd7, 2'b00);
    beat(18'd1,  18'd2,  18'd7, {stage_end, 1'b1});
  endtask

  task automatic get_feat(input string tag, input longint exp_d, input logic exp_eot);
    int n = 0;
    while (!feat_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_vld"}, feat_valid, 1);
    chk({tag, "_data"}, feat_data, exp_d);
    chk({tag, "_idx"}, feat_idx, exp_idx);
    chk({tag, "_eot"}, feat_stage_eot, exp_eot);
    if (feat_valid) exp_idx = exp_eot ? 0 : (exp_idx + 1) % 4096;
    @(negedge clk);
  endtask

  task automatic set_w(input logic signed [2:0] a, input logic signed [2:0] b,
                       input logic signed [2:0] c);
    weight0 = a; weight1 = b; weight2 = c;
  endtask

  initial begin
    rst = 1'b0; data_valid = 1'b0; data0 = '0; data1 = '0; data2 = '0; data_eot = '0;
    weight_valid = 1'b0; feat_ready = 1'b1;
    set_w(3'sd0, 3'sd0, 3'sd0);
    repeat (2) @(negedge clk);
    chk("rst_fvld", feat_valid, 0);
    chk("rst_fdata", feat_data, 0);
    chk("rst_idx", feat_idx, 0);
    chk("rst_err", err, 0);
    chk("rst_dry", data_ready, 1);
    chk("rst_wry", weight_ready, 0);
    rst = 1'b1;
    @(negedge clk);

    // Single feature with latency check
    set_w(-3'sd1, 3'sd2, 3'sd0);
    weight_valid = 1'b1;
    run_std(1'b0);
    chk("lat_t1", feat_valid, 0);
    @(negedge clk);
    chk("lat_t2", feat_valid, 0);
    @(negedge clk);
    chk("lat_t3", feat_valid, 1);
    get_feat("single", 20, 1'b0);
    chk("single_pulse", feat_valid, 0);

    // Stage boundary: this feature was idx 0, so two more then the closing one
    run_std(1'b0);
    get_feat("stg1", 20, 1'b0);
    run_std(1'b1);
    get_feat("stg2", 20, 1'b1);
    run_std(1'b0);
    get_feat("stg3", 20, 1'b0);

    // Backpressure: a beat waits at the input while the result is held
    feat_ready = 1'b0;
    run_std(1'b0);
    while (!feat_valid) @(negedge clk);
    data_valid = 1'b1; data0 = 18'd10; data1 = 18'd20; data2 = 18'd7; data_eot = 2'b00;
    for (int i = 0; i < 5; i++) begin
      chk("bp_dry", data_ready, 0);
      chk("bp_hold", feat_data, 20);
      chk("bp_vld", feat_valid, 1);
      @(negedge clk);
    end
    feat_ready = 1'b1;
    get_feat("bp_out", 20, 1'b0);
    beat(18'd10, 18'd20, 18'd7, 2'b00);
    beat(18'd4,  18'd5,  18'd7, 2'b00);
    beat(18'd3,  18'd5,  18'd7, 2'b00);
    beat(18'd1,  18'd2,  18'd7, 2'b01);
    get_feat("bp_next", 20, 1'b0);

    // Weight stall: accs 1,1,1 with weights 3,-4,1
    weight_valid = 1'b0;
    set_w(3'sd3, -3'sd4, 3'sd1);
    beat(18'd1, 18'd1, 18'd1, 2'b00);
    beat(18'd0, 18'd0, 18'd0, 2'b00);
    beat(18'd0, 18'd0, 18'd0, 2'b00);
    beat(18'd0, 18'd0, 18'd0, 2'b01);
    for (int i = 0; i < 4; i++) begin
      chk("ws_fvld", feat_valid, 0);
      chk("ws_wry", weight_ready, 1);
      @(negedge clk);
    end
    weight_valid = 1'b1;
    get_feat("ws_out", 0, 1'b0);

    // Framing: early eot on beat 2, then a feature missing its eot
    set_w(3'sd1, 3'sd1, 3'sd1);
    chk("fr_err0", err, 0);
    beat(18'd10, 18'd20, 18'd7, 2'b00);
    beat(18'd4,  18'd5,  18'd7, 2'b01);
    get_feat("fr_short", 21, 1'b0);
    chk("fr_err1", err, 1);
    beat(18'd10, 18'd20, 18'd7, 2'b00);
    beat(18'd4,  18'd5,  18'd7, 2'b00);
    beat(18'd3,  18'd5,  18'd7, 2'b00);
    beat(18'd1,  18'd2,  18'd7, 2'b00);
    get_feat("fr_noeot", 16, 1'b0);
    chk("fr_err_sticky", err, 1);

    // Reset mid-feature
    beat(18'd10, 18'd20, 18'd7, 2'b00);
    beat(18'd4,  18'd5,  18'd7, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_fvld", feat_valid, 0);
    chk("mr_fdata", feat_data, 0);
    chk("mr_idx", feat_idx, 0);
    chk("mr_eot", feat_stage_eot, 0);
    chk("mr_err", err, 0);
    chk("mr_dry", data_ready, 1);
    chk("mr_wry", weight_ready, 0);
    rst = 1'b1;
    exp_idx = 0;
    @(negedge clk);
    set_w(-3'sd1, 3'sd2, 3'sd0);
    run_std(1'b0);
    get_feat("mr_clean", 20, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/feature_sum_accum.md
Name: feature_sum_accum

Overview:
- Sits directly downstream of the integral-image read port fed by the rectangle address/weight generator.
- Consumes, per feature, four corner beats of three integral-image lanes (one per rectangle) plus one weight triple.
- Forms each rectangle sum with the corner sign pattern +,-,-,+ and outputs the weighted feature sum with the stage-end flag.
- Its output feeds the stage threshold/compare logic.

Parameters:
- W_DATA, 18, unsigned integral-image sample width.
- W_WEIGHT, 3, signed weight width.
- W_CNT, 12, width of the per-stage feature counter.
- W_FEAT (localparam) = W_DATA+W_WEIGHT+4, signed feature sum width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- data_valid  in  1  corner beat valid.
- data_ready  out  1  corner beat accepted when valid&ready.
- data0  in  W_DATA  rect0 integral sample.
- data1  in  W_DATA  rect1 integral sample.
- data2  in  W_DATA  rect2 integral sample.
- data_eot  in  2  [0] last corner of feature, [1] last feature of stage.
- weight_valid  in  1  weight triple valid.
- weight_ready  out  1  weight accepted when valid&ready.
- weight0  in  W_WEIGHT  signed rect0 weight.
- weight1  in  W_WEIGHT  signed rect1 weight.
- weight2  in  W_WEIGHT  signed rect2 weight.
- feat_valid  out  1  feature sum valid.
- feat_ready  in  1  downstream accept.
- feat_data  out  W_FEAT  signed weighted feature sum.
- feat_stage_eot  out  1  this feature closes a stage.
- feat_idx  out  W_CNT  index of feature within current stage.
- err  out  1  sticky framing error.

Behaviour:
- Reset (rst=0 at clk edge): state=ACC, corner=0, accumulators=0, feat_data=0, feat_valid=0, feat_stage_eot=0, feat_idx=0, err=0. data_ready=1 and weight_ready=0 after reset. Reset mid-feature discards partial accumulations.
- States and transitions:
  - ACC: data_ready=1. Per accepted beat, acc_k += sign(corner)*data_k, with +1 for corner 0 and 3, -1 for corner 1 and 2. Accumulators are signed, width W_DATA+2; data is zero-extended before the add. Corner increments per beat. The last beat (see framing) moves the block to WAIT_W, latches stage_eot_r=data_eot[1], and resets corner to 0.
  - WAIT_W: weight_ready=1, data_ready=0. On weight handshake, capture weights and go to MUL.
  - MUL: feat_data <= acc0*w0 + acc1*w1 + acc2*w2 (signed, full width W_FEAT, no saturation). feat_stage_eot <= stage_eot_r. Go to OUT.
  - OUT: feat_valid=1. feat_data, feat_stage_eot and feat_idx are held stable until feat_ready.
    - On handshake: clear accumulators and return to ACC.
    - feat_idx <= 0 if feat_stage_eot, else feat_idx+1. feat_idx wraps modulo 2^W_CNT.
- feat_valid never drops without a handshake.
- Latency: last corner accepted at cycle T, weight_valid already high → weight handshake at T+1, feat_valid at T+3. Next corner beat can be accepted the cycle after the feat handshake.
- Weight handshake happens only in WAIT_W; early weights wait upstream.
- Framing:
  - Last beat = data_eot[0]=1 OR corner==3.
  - If data_eot[0]=1 at corner<3: the feature ends early and err is set.
  - If corner==3 with data_eot[0]=0: the feature still ends and err is set.
  - err stays set until reset.
- data_eot[1] is sampled only on the last beat.
- Simultaneous events:
  - feat_ready high on entry to OUT → handshake that same cycle, so feat_valid is high for 1 cycle.
  - Inputs arriving while not in ACC/WAIT_W are ignored, because their ready is low.

Test Plan:
- Single feature. Lane0 corners 10,4,3,1 (acc 4); lane1 20,5,5,2 (acc 12); lane2 7,7,7,7 (acc 0). Weights -1,2,0; data_eot[0] on beat 4; feat_ready=1 → feat_data=20, feat_idx=0, feat_valid a single cycle at T+3.
- Stage boundary. Three back-to-back features, data_eot[1] on the third → feat_idx 0,1,2, feat_stage_eot=1 only on the third; a fourth feature reports feat_idx=0.
- Backpressure. Hold feat_ready=0 for 5 cycles in OUT while data_valid=1 → data_ready=0, feat_data stable, no beat consumed; release → next feature accumulates correctly.
- Weight stall. weight_valid=0 for 4 cycles after last corner → block waits in WAIT_W with feat_valid=0; weights 3,-4,1 with accs 1,1,1 → feat_data=0.
- Framing error. data_eot[0] on beat 2 → err=1, feature emitted from 2 corners (+c0-c1). Then 4 beats without eot → feature emitted, err remains 1.
- Reset mid-feature. Drive rst=0 after 2 corners → all outputs at reset values. Then a clean feature gives the same result as the single-feature test.
